// File: rtl/tw_pkg.sv
// Shared definitions for the 3-wire slave: default field widths, FSM states
// and the encoding of the command (RW) bit.
`timescale 1ns/1ps
package tw_pkg;

    localparam int TW_ADDR_BITS_DEF = 9;
    localparam int TW_DATA_BITS_DEF = 16;

    localparam logic TW_RW_WRITE = 1'b1;
    localparam logic TW_RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_FETCH,
        RD_DATA,
        WR_DATA,
        DONE
    } tw_state_t;

endpackage

// File: rtl/tw_edge_sync.sv
// Two-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
`timescale 1ns/1ps
module tw_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/threewire_slave.sv
// 3-wire (clock, chip-select, bidirectional data) register-access slave.
// Frame: cs low, RW bit (1 = write), address MSB first, data MSB first.
// Optional feature: define TW_SLAVE_ERR_CNT_EN to add the saturating
// 8-bit aborted-frame counter output out_err_count.
`timescale 1ns/1ps
module threewire_slave
    import tw_pkg::*;
#(
    parameter int ADDR_BITS = TW_ADDR_BITS_DEF,
    parameter int DATA_BITS = TW_DATA_BITS_DEF
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_tw_clock,
    input  logic                 in_tw_cs,
    inout  wire                  io_tw_data,
    output logic [ADDR_BITS-1:0] out_reg_addr,
    output logic [DATA_BITS-1:0] out_reg_wr_data,
    output logic                 out_reg_wr_en,
    output logic                 out_reg_rd_en,
    input  logic [DATA_BITS-1:0] in_reg_rd_data,
    output logic                 out_frame_error
`ifdef TW_SLAVE_ERR_CNT_EN
    ,
    output logic [7:0]           out_err_count
`endif
);

    // Counter must hold the longer of the two fields without wrapping
    localparam int FIELD_MAX = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CNT_W     = $clog2(FIELD_MAX + 1);

    logic w_twc_sync, w_twc_rise, w_twc_fall;
    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_dat, w_dat_rise, w_dat_fall;
    logic [3:0] w_unused_sync;

    tw_edge_sync #(.RST_VAL(1'b0)) u_sync_clk (
        .i_clk(in_clk), .i_rst(in_rst), .i_async(in_tw_clock),
        .o_sync(w_twc_sync), .o_rise(w_twc_rise), .o_fall(w_twc_fall)
    );

    tw_edge_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk(in_clk), .i_rst(in_rst), .i_async(in_tw_cs),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Data goes through the same depth as the clock so both stay aligned
    tw_edge_sync #(.RST_VAL(1'b0)) u_sync_dat (
        .i_clk(in_clk), .i_rst(in_rst), .i_async(io_tw_data),
        .o_sync(w_dat), .o_rise(w_dat_rise), .o_fall(w_dat_fall)
    );

    assign w_unused_sync = {w_twc_sync, w_cs_sync, w_dat_rise, w_dat_fall};

    tw_state_t              r_state, w_state_nxt;
    logic                   w_abort;
    logic                   w_last_addr, w_last_data;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_rw;
    logic [ADDR_BITS-1:0]   r_addr_sh;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_wr_data;
    logic                   r_wr_en;
    logic                   r_rd_en;
    logic                   r_err;
    logic                   r_oe;
    logic                   r_dout;
    logic                   w_drive;

    assign w_last_addr = (r_cnt == CNT_W'(ADDR_BITS - 1));
    assign w_last_data = (r_cnt == CNT_W'(DATA_BITS - 1));

    // State register
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a cs rising edge in an active phase wins over any bit edge
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) w_state_nxt = CMD;
            end
            CMD: begin
                if (w_cs_rise)       w_abort = 1'b1;
                else if (w_twc_rise) w_state_nxt = ADDR;
            end
            ADDR: begin
                if (w_cs_rise) begin
                    w_abort = 1'b1;
                end else if (w_twc_rise && w_last_addr) begin
                    w_state_nxt = (r_rw == TW_RW_WRITE) ? WR_DATA : RD_FETCH;
                end
            end
            RD_FETCH: begin
                if (w_cs_rise) w_abort = 1'b1;
                else           w_state_nxt = RD_DATA;
            end
            RD_DATA, WR_DATA: begin
                if (w_cs_rise)                         w_abort = 1'b1;
                else if (w_twc_rise && w_last_data)    w_state_nxt = DONE;
            end
            DONE: begin
                if (w_cs_rise) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = IDLE;
    end

    // Bit shifting, strobes and the output driver, all qualified by the decoded next state
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_cnt     <= '0;
            r_rw      <= 1'b0;
            r_addr_sh <= '0;
            r_addr    <= '0;
            r_shift   <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_err     <= 1'b0;
            r_oe      <= 1'b0;
            r_dout    <= 1'b0;
        end else begin
            r_wr_en <= (r_state == WR_DATA) && (w_state_nxt == DONE);
            r_rd_en <= (r_state == ADDR) && (w_state_nxt == RD_FETCH);
            r_err   <= w_abort;
            case (r_state)
                IDLE: r_cnt <= '0;
                CMD: begin
                    if (w_twc_rise) r_rw <= w_dat;
                end
                ADDR: begin
                    if (w_twc_rise) begin
                        r_addr_sh <= {r_addr_sh[ADDR_BITS-2:0], w_dat};
                        r_cnt     <= w_last_addr ? '0 : r_cnt + CNT_W'(1);
                        if (w_last_addr && !w_abort) r_addr <= {r_addr_sh[ADDR_BITS-2:0], w_dat};
                    end
                end
                RD_FETCH: r_shift <= in_reg_rd_data;
                RD_DATA: begin
                    if (w_twc_fall) begin
                        r_oe    <= 1'b1;
                        r_dout  <= r_shift[DATA_BITS-1];
                        r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
                    end
                    if (w_twc_rise) r_cnt <= r_cnt + CNT_W'(1);
                end
                WR_DATA: begin
                    if (w_twc_rise) begin
                        r_shift <= {r_shift[DATA_BITS-2:0], w_dat};
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                    if (w_state_nxt == DONE) r_wr_data <= {r_shift[DATA_BITS-2:0], w_dat};
                end
                default: ;
            endcase
            if (w_state_nxt == IDLE || w_state_nxt == DONE) r_oe <= 1'b0;
        end
    end

    // Release the line in the very cycle an abort is seen
    assign w_drive    = r_oe & ~w_cs_rise;
    assign io_tw_data = w_drive ? r_dout : 1'bz;

    assign out_reg_addr    = r_addr;
    assign out_reg_wr_data = r_wr_data;
    assign out_reg_wr_en   = r_wr_en;
    assign out_reg_rd_en   = r_rd_en;
    assign out_frame_error = r_err;

`ifdef TW_SLAVE_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Saturating count of aborted frames
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_err_count <= 8'd0;
        end else if (r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign out_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_threewire_slave.sv
`timescale 1ns/1ps
module tb_threewire_slave;

    localparam int  AB   = 9;
    localparam int  DB   = 16;
    localparam time HALF = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          twc = 1'b0;
    logic          cs  = 1'b1;
    logic          m_oe = 1'b0;
    logic          m_dout = 1'b0;
    wire           tw_data;
    logic [AB-1:0] addr;
    logic [DB-1:0] wr_data;
    logic          wr_en, rd_en, ferr;
    logic [DB-1:0] rd_data = '0;
`ifdef TW_SLAVE_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    assign tw_data = m_oe ? m_dout : 1'bz;

    always #5 clk = ~clk;

    threewire_slave #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .in_clk(clk),
        .in_rst(rst),
        .in_tw_clock(twc),
        .in_tw_cs(cs),
        .io_tw_data(tw_data),
        .out_reg_addr(addr),
        .out_reg_wr_data(wr_data),
        .out_reg_wr_en(wr_en),
        .out_reg_rd_en(rd_en),
        .in_reg_rd_data(rd_data),
        .out_frame_error(ferr)
`ifdef TW_SLAVE_ERR_CNT_EN
        ,
        .out_err_count(err_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe monitor, sampled on the falling clock edge
    int            wr_cnt = 0, rd_cnt = 0, err_pulses = 0;
    logic [AB-1:0] last_wr_addr = '0;
    logic [DB-1:0] last_wr_data = '0;
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= addr;
            last_wr_data <= wr_data;
        end
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (ferr)  err_pulses <= err_pulses + 1;
    end

    // Master-side bit helpers
    task automatic send_bit(input logic b);
        m_dout = b;
        #HALF twc = 1'b1;
        #HALF twc = 1'b0;
    endtask

    task automatic start_frame();
        cs   = 1'b0;
        m_oe = 1'b1;
        #HALF;
    endtask

    task automatic send_hdr(input logic rw, input logic [AB-1:0] a);
        send_bit(rw);
        for (int i = AB - 1; i >= 0; i--) send_bit(a[i]);
    endtask

    task automatic send_word(input logic [DB-1:0] d, input int n);
        for (int i = DB - 1; i >= DB - n; i--) send_bit(d[i]);
    endtask

    task automatic read_bits(input int n, output logic [DB-1:0] v);
        m_oe = 1'b0;
        v    = '0;
        for (int i = n - 1; i >= 0; i--) begin
            #HALF;
            v[i] = tw_data;
            twc  = 1'b1;
            #HALF twc = 1'b0;
        end
    endtask

    task automatic end_frame();
        #HALF;
        m_oe = 1'b0;
        cs   = 1'b1;
        #(2 * HALF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        if (addr !== '0)        begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_cmp++;
        if (wr_data !== '0)     begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_cmp++;
        if (wr_en !== 1'b0)     begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_cmp++;
        if (rd_en !== 1'b0)     begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_cmp++;
        if (ferr !== 1'b0)      begin n_bad++; $display("FAIL reset_frame_error: got %b want 0", ferr); end
        n_cmp++;
        if (dut.w_drive !== 1'b0) begin n_bad++; $display("FAIL reset_driver: got %b want 0", dut.w_drive); end
        n_cmp++;
`ifdef TW_SLAVE_ERR_CNT_EN
        if (err_cnt !== 8'd0)   begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_cnt); end
        n_cmp++;
`endif
        rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_write();
        int w0, r0, e0;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_pulses;
        start_frame();
        send_hdr(1'b1, 9'h0A5);
        send_word(16'hBEEF, DB);
        end_frame();
        if (wr_cnt - w0 !== 1)          begin n_bad++; $display("FAIL write_wr_pulses: got %0d want 1", wr_cnt - w0); end
        n_cmp++;
        if (last_wr_addr !== 9'h0A5)    begin n_bad++; $display("FAIL write_addr: got %h want 0a5", last_wr_addr); end
        n_cmp++;
        if (last_wr_data !== 16'hBEEF)  begin n_bad++; $display("FAIL write_data: got %h want beef", last_wr_data); end
        n_cmp++;
        if (rd_cnt - r0 !== 0)          begin n_bad++; $display("FAIL write_rd_pulses: got %0d want 0", rd_cnt - r0); end
        n_cmp++;
        if (err_pulses - e0 !== 0)      begin n_bad++; $display("FAIL write_err_pulses: got %0d want 0", err_pulses - e0); end
        n_cmp++;
        if (addr !== 9'h0A5)            begin n_bad++; $display("FAIL write_addr_held: got %h want 0a5", addr); end
        n_cmp++;
    endtask

    task automatic test_read();
        int w0, r0, e0;
        logic [DB-1:0] v;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_pulses;
        rd_data = 16'h1234;
        start_frame();
        send_hdr(1'b0, 9'h1FF);
        read_bits(DB, v);
        end_frame();
        if (v !== 16'h1234)             begin n_bad++; $display("FAIL read_data: got %h want 1234", v); end
        n_cmp++;
        if (rd_cnt - r0 !== 1)          begin n_bad++; $display("FAIL read_rd_pulses: got %0d want 1", rd_cnt - r0); end
        n_cmp++;
        if (wr_cnt - w0 !== 0)          begin n_bad++; $display("FAIL read_wr_pulses: got %0d want 0", wr_cnt - w0); end
        n_cmp++;
        if (err_pulses - e0 !== 0)      begin n_bad++; $display("FAIL read_err_pulses: got %0d want 0", err_pulses - e0); end
        n_cmp++;
        if (addr !== 9'h1FF)            begin n_bad++; $display("FAIL read_addr: got %h want 1ff", addr); end
        n_cmp++;
        if (dut.w_drive !== 1'b0)       begin n_bad++; $display("FAIL read_release: got %b want 0", dut.w_drive); end
        n_cmp++;
    endtask

    task automatic test_abort();
        int w0, e0;
        w0 = wr_cnt; e0 = err_pulses;
        start_frame();
        send_hdr(1'b1, 9'h033);
        send_word(16'hFFFF, 5);
        end_frame();
        if (wr_cnt - w0 !== 0)          begin n_bad++; $display("FAIL abort_wr_pulses: got %0d want 0", wr_cnt - w0); end
        n_cmp++;
        if (err_pulses - e0 !== 1)      begin n_bad++; $display("FAIL abort_err_pulses: got %0d want 1", err_pulses - e0); end
        n_cmp++;
`ifdef TW_SLAVE_ERR_CNT_EN
        if (err_cnt !== 8'd1)           begin n_bad++; $display("FAIL abort_err_count: got %0d want 1", err_cnt); end
        n_cmp++;
`endif
    endtask

    task automatic test_extra_clocks();
        int w0, e0;
        w0 = wr_cnt; e0 = err_pulses;
        start_frame();
        send_hdr(1'b1, 9'h155);
        send_word(16'h5A3C, DB);
        repeat (3) send_bit(1'b1);
        end_frame();
        if (wr_cnt - w0 !== 1)          begin n_bad++; $display("FAIL extra_wr_pulses: got %0d want 1", wr_cnt - w0); end
        n_cmp++;
        if (last_wr_data !== 16'h5A3C)  begin n_bad++; $display("FAIL extra_data: got %h want 5a3c", last_wr_data); end
        n_cmp++;
        if (last_wr_addr !== 9'h155)    begin n_bad++; $display("FAIL extra_addr: got %h want 155", last_wr_addr); end
        n_cmp++;
        w0 = wr_cnt;
        start_frame();
        send_hdr(1'b1, 9'h0F0);
        send_word(16'h0001, DB);
        end_frame();
        if (wr_cnt - w0 !== 1)          begin n_bad++; $display("FAIL next_wr_pulses: got %0d want 1", wr_cnt - w0); end
        n_cmp++;
        if (last_wr_addr !== 9'h0F0)    begin n_bad++; $display("FAIL next_addr: got %h want 0f0", last_wr_addr); end
        n_cmp++;
        if (last_wr_data !== 16'h0001)  begin n_bad++; $display("FAIL next_data: got %h want 0001", last_wr_data); end
        n_cmp++;
        if (err_pulses - e0 !== 0)      begin n_bad++; $display("FAIL extra_err_pulses: got %0d want 0", err_pulses - e0); end
        n_cmp++;
    endtask

    task automatic test_reset_midread();
        int w0, e0;
        logic [DB-1:0] v;
        w0 = wr_cnt; e0 = err_pulses;
        rd_data = 16'hA5A5;
        start_frame();
        send_hdr(1'b0, 9'h012);
        read_bits(6, v);
        #(HALF / 2);
        if (v[5:0] !== 6'h29)           begin n_bad++; $display("FAIL midread_bits: got %h want 29", v[5:0]); end
        n_cmp++;
        if (dut.w_drive !== 1'b1)       begin n_bad++; $display("FAIL midread_driving: got %b want 1", dut.w_drive); end
        n_cmp++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (dut.w_drive !== 1'b0)       begin n_bad++; $display("FAIL midreset_driver: got %b want 0", dut.w_drive); end
        n_cmp++;
        if ({addr, wr_data, wr_en, rd_en, ferr} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h/%h/%b%b%b want all 0", addr, wr_data, wr_en, rd_en, ferr);
        end
        n_cmp++;
        cs  = 1'b1;
        twc = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #(2 * HALF);
        if (err_pulses - e0 !== 0)      begin n_bad++; $display("FAIL midreset_err_pulses: got %0d want 0", err_pulses - e0); end
        n_cmp++;
        if (wr_cnt - w0 !== 0)          begin n_bad++; $display("FAIL midreset_wr_pulses: got %0d want 0", wr_cnt - w0); end
        n_cmp++;
`ifdef TW_SLAVE_ERR_CNT_EN
        if (err_cnt !== 8'd0)           begin n_bad++; $display("FAIL midreset_err_count: got %0d want 0", err_cnt); end
        n_cmp++;
`endif
    endtask

    task automatic test_back_to_back();
        int w0, r0, e0;
        logic [DB-1:0] v;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_pulses;
        start_frame();
        send_hdr(1'b1, 9'h1C3);
        send_word(16'h8001, DB);
        end_frame();
        rd_data = 16'h7E81;
        start_frame();
        send_hdr(1'b0, 9'h0AA);
        read_bits(DB, v);
        end_frame();
        if (wr_cnt - w0 !== 1)          begin n_bad++; $display("FAIL b2b_wr_pulses: got %0d want 1", wr_cnt - w0); end
        n_cmp++;
        if (last_wr_addr !== 9'h1C3)    begin n_bad++; $display("FAIL b2b_wr_addr: got %h want 1c3", last_wr_addr); end
        n_cmp++;
        if (last_wr_data !== 16'h8001)  begin n_bad++; $display("FAIL b2b_wr_data: got %h want 8001", last_wr_data); end
        n_cmp++;
        if (rd_cnt - r0 !== 1)          begin n_bad++; $display("FAIL b2b_rd_pulses: got %0d want 1", rd_cnt - r0); end
        n_cmp++;
        if (v !== 16'h7E81)             begin n_bad++; $display("FAIL b2b_rd_data: got %h want 7e81", v); end
        n_cmp++;
        if (addr !== 9'h0AA)            begin n_bad++; $display("FAIL b2b_rd_addr: got %h want 0aa", addr); end
        n_cmp++;
        if (err_pulses - e0 !== 0)      begin n_bad++; $display("FAIL b2b_err_pulses: got %0d want 0", err_pulses - e0); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_extra_clocks();
        test_reset_midread();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, limit 2ms", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
